// File: rtl/ifft_32p_seq_32bits.sv
// Iterative 32-point radix-2 DIF inverse FFT: loads one frame into a register bank,
// runs 80 in-place butterflies with per-stage halving, then streams results in natural order.
module ifft_32p_seq_32bits #(
  parameter int DATA_W = 32,
  parameter int TW_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_real,
  input  logic [DATA_W-1:0] s_imag,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_real,
  output logic [DATA_W-1:0] m_imag,
  output logic [4:0]        m_index,
  output logic              m_last
);

  localparam int PW = DATA_W + TW_W + 2;

  localparam logic signed [31:0] C0 = 32'sd1073741824;
  localparam logic signed [31:0] C1 = 32'sd1053110176;
  localparam logic signed [31:0] C2 = 32'sd992008094;
  localparam logic signed [31:0] C3 = 32'sd892783698;
  localparam logic signed [31:0] C4 = 32'sd759250125;
  localparam logic signed [31:0] C5 = 32'sd596538995;
  localparam logic signed [31:0] C6 = 32'sd410903207;
  localparam logic signed [31:0] C7 = 32'sd209476638;

  typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

  state_t state, state_nxt;
  logic [6:0] cnt, cnt_nxt;
  logic       load_we, bfly_we;

  logic signed [DATA_W-1:0] bank_re [32];
  logic signed [DATA_W-1:0] bank_im [32];

  logic [2:0] stage;
  logic [4:0] b5, span, mask, top_idx, bot_idx, tw_full, rev_idx;
  logic [3:0] tw_idx;
  logic signed [TW_W-1:0] w_re, w_im;

  logic signed [DATA_W-1:0] a_re, a_im, b_re, b_im;
  logic signed [DATA_W-1:0] top_re, top_im, bot_re, bot_im;
  logic signed [DATA_W:0]   sum_re, sum_im, dif_re, dif_im;
  logic signed [PW-1:0]     dre, dim, wre, wim, prod_re, prod_im;
  logic                     unused_bits;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // One counter serves as load index, butterfly step and unload index in turn.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    load_we   = 1'b0;
    bfly_we   = 1'b0;
    case (state)
      LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          load_we = 1'b1;
          if (cnt == 7'd31) begin
            state_nxt = COMPUTE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 7'd1;
          end
        end
      end
      COMPUTE: begin
        bfly_we = 1'b1;
        if (cnt == 7'd79) begin
          state_nxt = UNLOAD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 7'd1;
        end
      end
      UNLOAD: begin
        m_valid = 1'b1;
        if (m_ready) begin
          if (cnt == 7'd31) begin
            state_nxt = LOAD;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 7'd1;
          end
        end
      end
      default: begin
        state_nxt = LOAD;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign stage   = cnt[6:4];
  assign b5      = {1'b0, cnt[3:0]};
  assign span    = 5'd16 >> stage;
  assign mask    = span - 5'd1;
  assign top_idx = ((b5 & ~mask) << 1) | (b5 & mask);
  assign bot_idx = top_idx + span;
  assign tw_full = (b5 & mask) << stage;
  assign tw_idx  = tw_full[3:0];

  // Conjugate twiddles W[t] = cos(2*pi*t/32) + j*sin(2*pi*t/32) in Q2.30.
  always_comb begin
    w_re = '0;
    w_im = '0;
    case (tw_idx)
      4'd0:  begin w_re = C0;  w_im = '0; end
      4'd1:  begin w_re = C1;  w_im = C7; end
      4'd2:  begin w_re = C2;  w_im = C6; end
      4'd3:  begin w_re = C3;  w_im = C5; end
      4'd4:  begin w_re = C4;  w_im = C4; end
      4'd5:  begin w_re = C5;  w_im = C3; end
      4'd6:  begin w_re = C6;  w_im = C2; end
      4'd7:  begin w_re = C7;  w_im = C1; end
      4'd8:  begin w_re = '0;  w_im = C0; end
      4'd9:  begin w_re = -C7; w_im = C1; end
      4'd10: begin w_re = -C6; w_im = C2; end
      4'd11: begin w_re = -C5; w_im = C3; end
      4'd12: begin w_re = -C4; w_im = C4; end
      4'd13: begin w_re = -C3; w_im = C5; end
      4'd14: begin w_re = -C2; w_im = C6; end
      default: begin w_re = -C1; w_im = C7; end
    endcase
  end

  assign a_re = bank_re[top_idx];
  assign a_im = bank_im[top_idx];
  assign b_re = bank_re[bot_idx];
  assign b_im = bank_im[bot_idx];

  assign sum_re = {a_re[DATA_W-1], a_re} + {b_re[DATA_W-1], b_re};
  assign sum_im = {a_im[DATA_W-1], a_im} + {b_im[DATA_W-1], b_im};
  assign dif_re = {a_re[DATA_W-1], a_re} - {b_re[DATA_W-1], b_re};
  assign dif_im = {a_im[DATA_W-1], a_im} - {b_im[DATA_W-1], b_im};

  assign dre = PW'(dif_re);
  assign dim = PW'(dif_im);
  assign wre = PW'(w_re);
  assign wim = PW'(w_im);

  assign prod_re = dre * wre - dim * wim;
  assign prod_im = dre * wim + dim * wre;

  // Dropping low bits of two's-complement values truncates toward -inf.
  assign top_re = sum_re[DATA_W:1];
  assign top_im = sum_im[DATA_W:1];
  assign bot_re = prod_re[DATA_W+TW_W-2:TW_W-1];
  assign bot_im = prod_im[DATA_W+TW_W-2:TW_W-1];

  assign unused_bits = ^{sum_re[0], sum_im[0], tw_full[4],
                         prod_re[PW-1:DATA_W+TW_W-1], prod_re[TW_W-2:0],
                         prod_im[PW-1:DATA_W+TW_W-1], prod_im[TW_W-2:0]};

  always_ff @(posedge clk) begin
    if (load_we) begin
      bank_re[cnt[4:0]] <= s_real;
      bank_im[cnt[4:0]] <= s_imag;
    end else if (bfly_we) begin
      bank_re[top_idx] <= top_re;
      bank_im[top_idx] <= top_im;
      bank_re[bot_idx] <= bot_re;
      bank_im[bot_idx] <= bot_im;
    end
  end

  assign rev_idx = {cnt[0], cnt[1], cnt[2], cnt[3], cnt[4]};
  assign m_real  = m_valid ? bank_re[rev_idx] : '0;
  assign m_imag  = m_valid ? bank_im[rev_idx] : '0;
  assign m_index = m_valid ? cnt[4:0] : 5'd0;
  assign m_last  = m_valid && (cnt[4:0] == 5'd31);

endmodule

// File: tb/tb_ifft_32p_seq_32bits.sv
// Directed bench for ifft_32p_seq_32bits: impulse, DC, tone, stalls, latency and async reset.
module tb_ifft_32p_seq_32bits;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_real = '0;
  logic [31:0] s_imag = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_real;
  logic [31:0] m_imag;
  logic [4:0]  m_index;
  logic        m_last;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] frame_re [32];
  logic [31:0] frame_im [32];
  logic [31:0] exp_re [32];
  logic [31:0] exp_im [32];
  bit          exp_chk [32];
  int          tol;

  ifft_32p_seq_32bits dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_real  (s_real),
    .s_imag  (s_imag),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_real  (m_real),
    .m_imag  (m_imag),
    .m_index (m_index),
    .m_last  (m_last)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic checkNear(input string tag, input logic [31:0] obs, input logic [31:0] expv,
                           input int tl);
    longint diff;
    bit     ok;
    diff = longint'($signed(obs)) - longint'($signed(expv));
    ok = (diff <= longint'(tl)) && (diff >= -longint'(tl));
    compared++;
    assert (ok === 1'b1) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h tol=%0d", tag, obs, expv, tl);
    end
  endtask

  // Hand-derived expectations: impulse -> 0x10000/32 everywhere, DC -> impulse at n=0,
  // bin-1 tone -> 0x800*exp(j*2*pi*n/32), checked where the ideal value is an integer.
  task automatic setFrame(input int kind);
    for (int i = 0; i < 32; i++) begin
      frame_re[i] = '0;
      frame_im[i] = '0;
      exp_re[i]   = '0;
      exp_im[i]   = '0;
      exp_chk[i]  = 1'b1;
    end
    case (kind)
      0: begin
        frame_re[0] = 32'h0001_0000;
        for (int i = 0; i < 32; i++) exp_re[i] = 32'h0000_0800;
        tol = 0;
      end
      1: begin
        for (int i = 0; i < 32; i++) frame_re[i] = 32'h0001_0000;
        exp_re[0] = 32'h0001_0000;
        tol = 1;
      end
      default: begin
        frame_re[1] = 32'h0001_0000;
        for (int i = 0; i < 32; i++) exp_chk[i] = (i % 8 == 0);
        exp_re[0]  = 32'h0000_0800;
        exp_im[8]  = 32'h0000_0800;
        exp_re[16] = 32'hFFFF_F800;
        exp_im[24] = 32'hFFFF_F800;
        tol = 2;
      end
    endcase
  endtask

  // Streams frame_re/frame_im in; returns at the negedge just after the sample-31 transfer.
  task automatic applyStimulus(input bit gaps);
    int k;
    int guard;
    k = 0;
    guard = 0;
    while (k < 32 && guard < 500) begin
      @(negedge clk);
      s_valid = !(gaps && (guard % 3 == 1));
      s_real  = frame_re[k];
      s_imag  = frame_im[k];
      if (s_valid && s_ready) k++;
      guard++;
    end
    checkEq("load_count", 32'(k), 32'd32);
    @(negedge clk);
    s_valid = 1'b0;
    s_real  = '0;
    s_imag  = '0;
  endtask

  task automatic waitResult(input string tag);
    int edges;
    edges = 0;
    while (!m_valid && edges < 200) begin
      if (edges == 40) checkEq({tag, "_s_ready_compute"}, 32'(s_ready), 32'd0);
      @(negedge clk);
      edges++;
    end
    checkEq({tag, "_latency"}, 32'(edges), 32'd80);
  endtask

  task automatic checkOutput(input string tag, input bit gaps);
    int n;
    int guard;
    n = 0;
    guard = 0;
    while (n < 32 && guard < 300) begin
      m_ready = !(gaps && (guard % 4 == 2));
      checkEq({tag, "_valid"}, 32'(m_valid), 32'd1);
      checkEq({tag, "_s_ready"}, 32'(s_ready), 32'd0);
      checkEq({tag, "_index"}, 32'(m_index), 32'(n));
      checkEq({tag, "_last"}, 32'(m_last), 32'(n == 31));
      if (exp_chk[n]) begin
        checkNear($sformatf("%s_re[%0d]", tag, n), m_real, exp_re[n], tol);
        checkNear($sformatf("%s_im[%0d]", tag, n), m_imag, exp_im[n], tol);
      end
      if (m_valid && m_ready) n++;
      guard++;
      @(negedge clk);
    end
    m_ready = 1'b0;
    checkEq({tag, "_out_count"}, 32'(n), 32'd32);
    checkEq({tag, "_s_ready_after"}, 32'(s_ready), 32'd1);
    checkEq({tag, "_m_valid_after"}, 32'(m_valid), 32'd0);
  endtask

  initial begin
    $display("[TB] reset state");
    repeat (2) @(negedge clk);
    checkEq("rst_s_ready", 32'(s_ready), 32'd1);
    checkEq("rst_m_valid", 32'(m_valid), 32'd0);
    checkEq("rst_m_last", 32'(m_last), 32'd0);
    checkEq("rst_m_index", 32'(m_index), 32'd0);
    checkEq("rst_m_real", m_real, 32'd0);
    checkEq("rst_m_imag", m_imag, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] impulse frame");
    setFrame(0);
    applyStimulus(1'b0);
    waitResult("imp");
    checkOutput("imp", 1'b0);

    $display("[TB] dc frame");
    setFrame(1);
    applyStimulus(1'b0);
    waitResult("dc");
    checkOutput("dc", 1'b0);

    $display("[TB] single tone frame");
    setFrame(2);
    applyStimulus(1'b0);
    waitResult("tone");
    checkOutput("tone", 1'b0);

    $display("[TB] stalled handshakes");
    setFrame(0);
    applyStimulus(1'b1);
    waitResult("imp_gap");
    checkOutput("imp_gap", 1'b1);
    setFrame(1);
    applyStimulus(1'b1);
    waitResult("dc_gap");
    checkOutput("dc_gap", 1'b1);

    $display("[TB] reset during compute");
    setFrame(0);
    applyStimulus(1'b0);
    repeat (40) @(negedge clk);
    rst = 1'b1;
    #1;
    checkEq("async_s_ready", 32'(s_ready), 32'd1);
    checkEq("async_m_valid", 32'(m_valid), 32'd0);
    checkEq("async_m_index", 32'(m_index), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0);
    waitResult("post_rst");
    checkOutput("post_rst", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
